adc_serial_capture: RTL and testbench

- Drives the radar ADC's 3-wire serial port (ADC_nCS, ADC_SClk, ADC_Data) on the DSP clock.
- Converts each triggered conversion frame into a parallel sample with a one-cycle valid strobe.
- Sits directly downstream of the platform pin mapping and upstream of the range-FFT/DSP chain.
- One frame is run per Trigger pulse; the synthesiser ramp timing provides the pulse.

---
 rtl/adc_serial_capture_if.sv | 26 ++
 rtl/adc_serial_capture.sv | 147 ++++++++++++++
 tb/tb_adc_serial_capture.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_serial_capture_if.sv
// Signal bundle for the radar ADC capture block: the three ADC serial pins plus the
// trigger, sample and status lines facing the DSP chain.
interface adc_serial_capture_if #(
  parameter int SampleBits = 12
);
  logic                  Trigger;
  logic                  ADC_nCS;
  logic                  ADC_SClk;
  logic                  ADC_Data;
  logic [SampleBits-1:0] Sample;
  logic                  Valid;
  logic                  Busy;
  logic                  Overrun;

  // Valid is a one-cycle strobe with no back-pressure: Sample is good while Valid is high
  // and holds until the next strobe. A Trigger seen while Busy is dropped and flagged on Overrun.
  modport master (
    input  Trigger, ADC_Data,
    output ADC_nCS, ADC_SClk, Sample, Valid, Busy, Overrun
  );

  modport slave (
    output Trigger, ADC_Data,
    input  ADC_nCS, ADC_SClk, Sample, Valid, Busy, Overrun
  );
endinterface

// File: rtl/adc_serial_capture.sv
// Runs one 3-wire ADC conversion frame per Trigger and presents the captured sample
// as a parallel word with a one-cycle Valid strobe.
module adc_serial_capture #(
  parameter int ClockDiv     = 2,
  parameter int Bits         = 16,
  parameter int LeadingZeros = 4,
  parameter int SampleBits   = 12,
  parameter int QuietCycles  = 8,
  parameter int OffsetBinary = 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  adc_serial_capture_if.master        bus,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  localparam int MaxCount = (ClockDiv > QuietCycles)
                          ? ((ClockDiv > Bits) ? ClockDiv : Bits)
                          : ((QuietCycles > Bits) ? QuietCycles : Bits);
  localparam int CW = $clog2(MaxCount + 1);
  localparam int BW = $clog2(Bits);
  // Only the bits that can reach the sample window are kept; leading zeros fall off the top.
  localparam int SW = Bits - LeadingZeros;

  localparam logic [CW-1:0] DivLast   = CW'(ClockDiv - 1);
  localparam logic [CW-1:0] QuietLast = CW'((QuietCycles > 0) ? QuietCycles - 1 : 0);
  localparam logic [BW-1:0] BitLast   = BW'(Bits - 1);
  localparam logic [SampleBits-1:0] MsbFlip = {(OffsetBinary != 0), {(SampleBits-1){1'b0}}};

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_cnt;
  logic [SW-1:0]         shift;
  logic                  data_reg;
  logic                  done;
  logic                  ncs;
  logic                  sclk;
  logic [SampleBits-1:0] sample;
  logic                  valid;
  logic                  busy;
  logic                  overrun;
  logic [SampleBits-1:0] raw_sample;

  assign raw_sample = shift[SW-1 -: SampleBits];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data_reg <= 1'b0;
      done     <= 1'b0;
      ncs      <= 1'b1;
      sclk     <= 1'b1;
      sample   <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      data_reg <= bus.ADC_Data;
      overrun  <= bus.Trigger & busy;
      // The sample is formed from the completed shift register one cycle after the
      // last capture, so Valid trails the nCS rise by one cycle.
      valid    <= done;
      done     <= 1'b0;
      if (done) begin
        sample <= raw_sample ^ MsbFlip;
      end

      case (state)
        IDLE: begin
          if (bus.Trigger) begin
            state <= SETUP;
            ncs   <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end

        SETUP: begin
          if (cnt == DivLast) begin
            cnt     <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (cnt == DivLast) begin
            cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // End of a high phase: the ADC data has been stable since the falling edge.
              shift <= {shift[SW-2:0], data_reg};
              if (bit_cnt == BitLast) begin
                bit_cnt <= '0;
                ncs     <= 1'b1;
                done    <= 1'b1;
                state   <= QUIET;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sclk    <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        QUIET: begin
          if (cnt == QuietLast) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ADC_nCS  = ncs;
  assign bus.ADC_SClk = sclk;
  assign bus.Sample   = sample;
  assign bus.Valid    = valid;
  assign bus.Busy     = busy;
  assign bus.Overrun  = overrun;
  assign dbg_state    = state;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture: three parameterisations, an ADC model per
// instance and a shared scoreboard of {instance, sample} entries.
module tb_adc_serial_capture;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd2;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  int   cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // ---------------- DUTs ----------------
  adc_serial_capture_if #(.SampleBits(12)) bus0 ();
  adc_serial_capture_if #(.SampleBits(12)) bus1 ();
  adc_serial_capture_if #(.SampleBits(12)) bus2 ();
  logic [1:0] st0, st1, st2;

  adc_serial_capture u_def (
    .Clk(Clk), .Reset(Reset), .bus(bus0), .dbg_state(st0)
  );

  adc_serial_capture #(.OffsetBinary(0)) u_bin (
    .Clk(Clk), .Reset(Reset), .bus(bus1), .dbg_state(st1)
  );

  adc_serial_capture #(.ClockDiv(1), .Bits(14), .LeadingZeros(2), .SampleBits(12),
                       .QuietCycles(8), .OffsetBinary(1)) u_fast (
    .Clk(Clk), .Reset(Reset), .bus(bus2), .dbg_state(st2)
  );

  logic        trig[3];
  logic        adc_data[3];
  logic        ncs[3], sclk[3], valid[3], busy[3], ovr[3];
  logic [11:0] smp[3];
  logic [1:0]  st[3];

  assign bus0.Trigger = trig[0];  assign bus0.ADC_Data = adc_data[0];
  assign bus1.Trigger = trig[1];  assign bus1.ADC_Data = adc_data[1];
  assign bus2.Trigger = trig[2];  assign bus2.ADC_Data = adc_data[2];

  assign ncs[0] = bus0.ADC_nCS;  assign sclk[0] = bus0.ADC_SClk;  assign valid[0] = bus0.Valid;
  assign ncs[1] = bus1.ADC_nCS;  assign sclk[1] = bus1.ADC_SClk;  assign valid[1] = bus1.Valid;
  assign ncs[2] = bus2.ADC_nCS;  assign sclk[2] = bus2.ADC_SClk;  assign valid[2] = bus2.Valid;
  assign busy[0] = bus0.Busy;    assign ovr[0] = bus0.Overrun;    assign smp[0] = bus0.Sample;
  assign busy[1] = bus1.Busy;    assign ovr[1] = bus1.Overrun;    assign smp[1] = bus1.Sample;
  assign busy[2] = bus2.Busy;    assign ovr[2] = bus2.Overrun;    assign smp[2] = bus2.Sample;
  assign st[0] = st0;  assign st[1] = st1;  assign st[2] = st2;

  // ---------------- scoreboard state ----------------
  logic [13:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  int valid_cnt[3], valid_edge[3], ovr_cnt[3], hold_err[3];
  int low_run[3], high_run[3], last_low_len[3], last_high_len[3];
  int sclk_low[3], sclk_pulses[3], sclk_min[3], sclk_max[3];
  int adc_idx[3], adc_bits[3];
  logic [15:0] adc_word[3];
  logic [11:0] exp_hold[3];
  logic        prev_ncs[3], prev_sclk[3];
  logic        rst_prev = 1'b1;

  logic [15:0] bin_words[4] = '{16'h0000, 16'h0FFF, 16'h0800, 16'hA123};
  logic [11:0] bin_outs[4]  = '{12'h000, 12'hFFF, 12'h800, 12'h123};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic fail(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: event missing or unexpected", tag);
  endtask

  function automatic void push(input int k, input logic [11:0] v);
    exp_q.push_back({k[1:0], v});
  endfunction

  // ---------------- monitor + ADC model (negedge, away from the active edge) ----------------
  always @(negedge Clk) begin : mon
    logic [13:0] e;
    for (int k = 0; k < 3; k++) begin
      if (valid[k]) begin
        valid_cnt[k]++;
        valid_edge[k] = cyc;
        if (exp_q.size() == 0) begin
          fail("unexpected_valid");
        end else begin
          e = exp_q.pop_front();
          check("sample", {18'd0, k[1:0], smp[k]}, {18'd0, e});
        end
        exp_hold[k] = smp[k];
      end else begin
        if (rst_prev) exp_hold[k] = '0;
        if (smp[k] !== exp_hold[k]) hold_err[k]++;
      end
      if (ovr[k]) ovr_cnt[k]++;

      if (!ncs[k]) begin
        if (prev_ncs[k]) begin
          last_high_len[k] = high_run[k];
          high_run[k] = 0;
          sclk_pulses[k] = 0;
          sclk_min[k] = 1000;
          sclk_max[k] = 0;
          sclk_low[k] = 0;
          adc_idx[k] = 0;
        end
        low_run[k]++;
      end else begin
        if (!prev_ncs[k]) begin
          last_low_len[k] = low_run[k];
          low_run[k] = 0;
        end
        high_run[k]++;
      end

      if (!sclk[k]) begin
        sclk_low[k]++;
      end else if (sclk_low[k] > 0) begin
        sclk_pulses[k]++;
        if (sclk_low[k] < sclk_min[k]) sclk_min[k] = sclk_low[k];
        if (sclk_low[k] > sclk_max[k]) sclk_max[k] = sclk_low[k];
        sclk_low[k] = 0;
      end

      // ADC presents the next bit, MSB first, after each SClk falling edge.
      if (!ncs[k] && prev_sclk[k] && !sclk[k] && adc_idx[k] < adc_bits[k]) begin
        adc_data[k] = adc_word[k][adc_bits[k] - 1 - adc_idx[k]];
        adc_idx[k]++;
      end
      prev_ncs[k]  = ncs[k];
      prev_sclk[k] = sclk[k];
    end
    rst_prev = Reset;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic pulse_trig(input int k, output int t_edge);
    tick();
    trig[k] = 1'b1;
    t_edge = cyc + 1;
    tick();
    trig[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, input int budget, output int v_edge);
    int start;
    int n;
    start = valid_cnt[k];
    n = 0;
    v_edge = -1;
    while (valid_cnt[k] == start && n < budget) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (valid_cnt[k] == start) fail("valid_timeout");
    else v_edge = valid_edge[k];
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n;
    n = 0;
    while (!(busy[k] === 1'b0 && st[k] === S_IDLE) && n < budget) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (!(busy[k] === 1'b0 && st[k] === S_IDLE)) fail("idle_timeout");
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int t, t2, t3, v, ob, vb;
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      trig[k] = 1'b0;     adc_data[k] = 1'b0;  adc_word[k] = '0;
      valid_cnt[k] = 0;   valid_edge[k] = 0;   ovr_cnt[k] = 0;    hold_err[k] = 0;
      low_run[k] = 0;     high_run[k] = 0;     last_low_len[k] = 0; last_high_len[k] = 0;
      sclk_low[k] = 0;    sclk_pulses[k] = 0;  sclk_min[k] = 1000; sclk_max[k] = 0;
      adc_idx[k] = 0;     exp_hold[k] = '0;    prev_ncs[k] = 1'b1; prev_sclk[k] = 1'b1;
    end
    adc_bits[0] = 16;  adc_bits[1] = 16;  adc_bits[2] = 14;

    repeat (3) tick();
    check("rst_ncs", ncs[0], 1);
    check("rst_sclk", sclk[0], 1);
    check("rst_valid", valid[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_overrun", ovr[0], 0);
    check("rst_sample", smp[0], 0);
    check("rst_state", st[0], S_IDLE);
    check("rst_fast_ncs", ncs[2], 1);
    Reset = 1'b0;

    // Default parameters, 0x0ABC -> 0x2BC
    adc_word[0] = 16'h0ABC;
    push(0, 12'h2BC);
    ob = ovr_cnt[0];
    pulse_trig(0, t);
    wait_valid(0, 200, v);
    check("lat_default", v - t, 67);
    wait_idle(0, 100);
    check("ncs_low_len", last_low_len[0], 66);
    check("sclk_pulses", sclk_pulses[0], 16);
    check("sclk_low_min", sclk_min[0], 2);
    check("sclk_low_max", sclk_max[0], 2);
    check("no_overrun", ovr_cnt[0] - ob, 0);

    // OffsetBinary=0 frames; sample must hold between strobes
    for (int i = 0; i < 4; i++) begin
      adc_word[1] = bin_words[i];
      push(1, bin_outs[i]);
      pulse_trig(1, t);
      wait_valid(1, 200, v);
      check("lat_bin", v - t, 67);
      wait_idle(1, 100);
      repeat (5) tick();
      check("hold_bin", smp[1], bin_outs[i]);
    end

    // Overruns: one during SHIFT, one during QUIET, then a clean frame
    adc_word[0] = 16'h0ABC;
    push(0, 12'h2BC);
    ob = ovr_cnt[0];
    vb = valid_cnt[0];
    pulse_trig(0, t);
    repeat (8) tick();
    pulse_trig(0, t2);
    wait_valid(0, 200, v);
    check("lat_overrun_frame", v - t, 67);
    tick();
    pulse_trig(0, t3);
    wait_idle(0, 100);
    check("overrun_count", ovr_cnt[0] - ob, 2);
    check("one_frame", valid_cnt[0] - vb, 1);
    adc_word[0] = 16'h0555;
    push(0, 12'hD55);
    pulse_trig(0, t);
    wait_valid(0, 200, v);
    check("lat_after_overrun", v - t, 67);
    wait_idle(0, 100);

    // Reset while SHIFT is on bit 7
    adc_word[0] = 16'h0ABC;
    vb = valid_cnt[0];
    pulse_trig(0, t);
    repeat (31) tick();
    check("mid_state_shift", st[0], S_SHIFT);
    Reset = 1'b1;
    tick();
    check("mid_rst_ncs", ncs[0], 1);
    check("mid_rst_sclk", sclk[0], 1);
    check("mid_rst_valid", valid[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_state", st[0], S_IDLE);
    check("mid_rst_sample", smp[0], 0);
    Reset = 1'b0;
    repeat (80) tick();
    check("no_partial_sample", valid_cnt[0] - vb, 0);
    adc_word[0] = 16'h0123;
    push(0, 12'h923);
    pulse_trig(0, t);
    wait_valid(0, 200, v);
    check("lat_after_reset", v - t, 67);
    wait_idle(0, 100);

    // ClockDiv=1, Bits=14, LeadingZeros=2, all ones
    adc_word[2] = 16'h3FFF;
    push(2, 12'h7FF);
    pulse_trig(2, t);
    wait_valid(2, 100, v);
    check("lat_fast", v - t, 30);
    wait_idle(2, 100);
    check("fast_ncs_low_len", last_low_len[2], 29);
    check("fast_sclk_pulses", sclk_pulses[2], 14);
    check("fast_sclk_low_max", sclk_max[2], 1);

    // Trigger held for 200 cycles: three back-to-back frames, Overrun on every busy cycle
    adc_word[0] = 16'h0ABC;
    push(0, 12'h2BC);
    push(0, 12'h2BC);
    push(0, 12'h2BC);
    ob = ovr_cnt[0];
    vb = valid_cnt[0];
    tick();
    trig[0] = 1'b1;
    repeat (200) tick();
    trig[0] = 1'b0;
    wait_idle(0, 300);
    check("held_frames", valid_cnt[0] - vb, 3);
    check("held_overruns", ovr_cnt[0] - ob, 197);
    check("held_ncs_gap", last_high_len[0], 9);
    check("held_ncs_low_len", last_low_len[0], 66);

    repeat (5) tick();
    check("queue_empty", exp_q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      check("sample_hold", hold_err[k], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
